// File: rtl/execute_hi_lo_unit.sv
// HI/LO register unit for the execute stage: moves, single-cycle multiplies and a
// 32-cycle restoring divider that stalls the pipeline while it runs.
module execute_hi_lo_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        hi_lo_register_write_execute,
    input  logic [5:0]  ALU_function_execute,
    input  logic [31:0] source_A_execute,
    input  logic [31:0] source_B_execute,
    output logic [31:0] hi_lo_read_data_execute,
    output logic        hi_lo_busy_execute,
    output logic [31:0] hi_register,
    output logic [31:0] lo_register
);

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic {IDLE, DIVIDING} state_t;

    state_t      state;
    state_t      next_state;
    logic [4:0]  count;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [31:0] divisor;
    logic        negate_q;
    logic        negate_r;

    logic        accept;
    logic        start_div;
    logic        is_signed_div;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic        fits;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] final_q;
    logic [31:0] final_r;
    logic        last;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    assign accept        = hi_lo_register_write_execute && !clear && (state == IDLE);
    assign is_signed_div = (ALU_function_execute == FN_DIV);
    assign start_div     = accept && (source_B_execute != 32'd0) &&
                           ((ALU_function_execute == FN_DIV) || (ALU_function_execute == FN_DIVU));

    // Signed divides run on magnitudes; signs are reapplied when the result is written.
    assign a_mag = (is_signed_div && source_A_execute[31]) ? -source_A_execute : source_A_execute;
    assign b_mag = (is_signed_div && source_B_execute[31]) ? -source_B_execute : source_B_execute;

    assign shifted  = {remainder, quotient[31]};
    assign trial    = shifted - {1'b0, divisor};
    assign fits     = !trial[32];
    assign rem_next = fits ? trial[31:0] : shifted[31:0];
    assign quo_next = {quotient[30:0], fits};
    assign final_q  = negate_q ? -quo_next : quo_next;
    assign final_r  = negate_r ? -rem_next : rem_next;
    assign last     = (count == 5'd31);

    assign prod_s = $signed({{32{source_A_execute[31]}}, source_A_execute}) *
                    $signed({{32{source_B_execute[31]}}, source_B_execute});
    assign prod_u = {32'd0, source_A_execute} * {32'd0, source_B_execute};

    assign hi_lo_busy_execute = (state == DIVIDING);

    always_comb begin
        hi_lo_read_data_execute = 32'd0;
        if (ALU_function_execute == FN_MFHI)
            hi_lo_read_data_execute = hi_register;
        else if (ALU_function_execute == FN_MFLO)
            hi_lo_read_data_execute = lo_register;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start_div) next_state = DIVIDING;
            DIVIDING: if (clear || last) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            hi_register <= 32'd0;
            lo_register <= 32'd0;
            count       <= 5'd0;
            quotient    <= 32'd0;
            remainder   <= 32'd0;
            divisor     <= 32'd0;
            negate_q    <= 1'b0;
            negate_r    <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE) begin
                if (accept) begin
                    case (ALU_function_execute)
                        FN_MTHI:  hi_register <= source_A_execute;
                        FN_MTLO:  lo_register <= source_A_execute;
                        FN_MULT:  {hi_register, lo_register} <= prod_s;
                        FN_MULTU: {hi_register, lo_register} <= prod_u;
                        FN_DIV, FN_DIVU: begin
                            if (source_B_execute == 32'd0) begin
                                hi_register <= source_A_execute;
                                lo_register <= 32'hFFFF_FFFF;
                            end else begin
                                remainder <= 32'd0;
                                quotient  <= a_mag;
                                divisor   <= b_mag;
                                count     <= 5'd0;
                                negate_q  <= is_signed_div &&
                                             (source_A_execute[31] ^ source_B_execute[31]);
                                negate_r  <= is_signed_div && source_A_execute[31];
                            end
                        end
                        default: ;
                    endcase
                end
            end else if (!clear) begin
                remainder <= rem_next;
                quotient  <= quo_next;
                count     <= count + 5'd1;
                if (last) begin
                    hi_register <= final_r;
                    lo_register <= final_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_execute_hi_lo_unit.sv
// Randomized self-checking bench for execute_hi_lo_unit against an arithmetic
// reference model of HI/LO and divider latency.
module tb_execute_hi_lo_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        we;
    logic [5:0]  funct;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] read_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model_hi;
    logic [31:0] model_lo;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    int          div_left;
    logic [31:0] rd_seen;
    logic [31:0] rd_exp;

    execute_hi_lo_unit dut (
        .clk                          (clk),
        .reset_n                      (reset_n),
        .clear                        (clear),
        .hi_lo_register_write_execute (we),
        .ALU_function_execute         (funct),
        .source_A_execute             (src_a),
        .source_B_execute             (src_b),
        .hi_lo_read_data_execute      (read_data),
        .hi_lo_busy_execute           (busy),
        .hi_register                  (hi),
        .lo_register                  (lo)
    );

    always #5 clk = ~clk;

    // Reference: HI/LO as plain values, a divide as a countdown plus a precomputed result.
    task automatic model_step(input logic w, input logic [5:0] f, input logic [31:0] a,
                              input logic [31:0] b, input logic c);
        int     sa;
        int     sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = a;
        sb = b;
        if (div_left > 0) begin
            if (c) div_left = 0;
            else begin
                div_left--;
                if (div_left == 0) begin
                    model_hi = pend_hi;
                    model_lo = pend_lo;
                end
            end
        end else if (w && !c) begin
            case (f)
                6'h11: model_hi = a;
                6'h13: model_lo = a;
                6'h18: begin
                    p = 64'(longint'(sa) * longint'(sb));
                    model_hi = p[63:32];
                    model_lo = p[31:0];
                end
                6'h19: begin
                    p = 64'(a) * 64'(b);
                    model_hi = p[63:32];
                    model_lo = p[31:0];
                end
                6'h1A, 6'h1B: begin
                    if (b == 32'd0) begin
                        model_hi = a;
                        model_lo = 32'hFFFF_FFFF;
                    end else begin
                        if (f == 6'h1A) begin
                            q = longint'(sa) / longint'(sb);
                            r = longint'(sa) % longint'(sb);
                            pend_lo = 32'(q);
                            pend_hi = 32'(r);
                        end else begin
                            pend_lo = a / b;
                            pend_hi = a % b;
                        end
                        div_left = 32;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Entered and left at posedge+1: drive, sample read data, clock, advance model.
    task automatic drive_cycle(input logic w, input logic [5:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic c);
        we    = w;
        funct = f;
        src_a = a;
        src_b = b;
        clear = c;
        #1;
        rd_seen = read_data;
        rd_exp  = (f == 6'h10) ? model_hi : (f == 6'h12) ? model_lo : 32'd0;
        @(posedge clk);
        model_step(w, f, a, b, c);
        #1;
    endtask

    task automatic test_reset;
        we = 0; funct = 0; src_a = 0; src_b = 0; clear = 0;
        reset_n = 0;
        model_hi = 0; model_lo = 0; div_left = 0; pend_hi = 0; pend_lo = 0;
        #23;
        if (hi !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_hi: got %h, expected 0", hi); end
        vectors++;
        if (lo !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_lo: got %h, expected 0", lo); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        vectors++;
        reset_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_move;
        logic [31:0] v;
        for (int i = 0; i < 6; i++) begin
            v = $urandom;
            drive_cycle(1, (i % 2 == 0) ? 6'h11 : 6'h13, v, $urandom, 0);
            drive_cycle(1, (i % 2 == 0) ? 6'h10 : 6'h12, $urandom, $urandom, 0);
            if (rd_seen !== v) begin miscompares++; $display("[TB] FAIL move_read: got %h, expected %h", rd_seen, v); end
            vectors++;
            if (hi !== model_hi || lo !== model_lo) begin
                miscompares++; $display("[TB] FAIL move_regs: got %h/%h, expected %h/%h", hi, lo, model_hi, model_lo);
            end
            vectors++;
        end
        drive_cycle(1, 6'h11, 32'hDEAD_BEEF, 0, 1);
        if (hi !== model_hi) begin miscompares++; $display("[TB] FAIL clear_blocks: got %h, expected %h", hi, model_hi); end
        vectors++;
        drive_cycle(1, 6'h21, 32'hCAFE_F00D, 32'h1234, 0);
        if (hi !== model_hi || lo !== model_lo) begin
            miscompares++; $display("[TB] FAIL unlisted_noop: got %h/%h, expected %h/%h", hi, lo, model_hi, model_lo);
        end
        vectors++;
        drive_cycle(0, 6'h10, 0, 0, 0);
        if (rd_seen !== model_hi) begin miscompares++; $display("[TB] FAIL read_no_we: got %h, expected %h", rd_seen, model_hi); end
        vectors++;
    endtask

    task automatic test_mult;
        logic [31:0] a;
        logic [31:0] b;
        drive_cycle(1, 6'h18, 32'hFFFF_FFFE, 32'h3, 0);
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
            miscompares++; $display("[TB] FAIL mult_fixed: got %h/%h, expected ffffffff/fffffffa", hi, lo);
        end
        vectors++;
        drive_cycle(1, 6'h19, 32'hFFFF_FFFE, 32'h3, 0);
        if (hi !== 32'h2 || lo !== 32'hFFFF_FFFA) begin
            miscompares++; $display("[TB] FAIL multu_fixed: got %h/%h, expected 00000002/fffffffa", hi, lo);
        end
        vectors++;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            drive_cycle(1, (i % 2 == 0) ? 6'h18 : 6'h19, a, b, 0);
            if (hi !== model_hi || lo !== model_lo) begin
                miscompares++; $display("[TB] FAIL mult_rand: a=%h b=%h got %h/%h, expected %h/%h", a, b, hi, lo, model_hi, model_lo);
            end
            vectors++;
        end
    endtask

    task automatic test_divide;
        logic [31:0] prior_lo;
        logic [31:0] a;
        logic [31:0] b;
        drive_cycle(1, 6'h13, 32'h5555_0000, 0, 0);
        prior_lo = model_lo;
        drive_cycle(1, 6'h1B, 32'd100, 32'd7, 0);
        for (int i = 0; i < 32; i++) begin
            if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL divu_busy: cycle %0d got %b, expected 1", i, busy); end
            vectors++;
            drive_cycle(1, 6'h12, $urandom, $urandom, 0);
            if (rd_seen !== prior_lo) begin miscompares++; $display("[TB] FAIL mflo_busy: got %h, expected %h", rd_seen, prior_lo); end
            vectors++;
        end
        if (busy !== 1'b0 || hi !== 32'd2 || lo !== 32'd14) begin
            miscompares++; $display("[TB] FAIL divu_result: got busy=%b %h/%h, expected 0 00000002/0000000e", busy, hi, lo);
        end
        vectors++;

        drive_cycle(1, 6'h1A, 32'hFFFF_FFF9, 32'd2, 0);
        repeat (32) drive_cycle(0, 0, $urandom, $urandom, 0);
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            miscompares++; $display("[TB] FAIL div_neg: got %h/%h, expected ffffffff/fffffffd", hi, lo);
        end
        vectors++;

        drive_cycle(1, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        repeat (32) drive_cycle(0, 0, 0, 0, 0);
        if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
            miscompares++; $display("[TB] FAIL div_overflow: got %h/%h, expected 00000000/80000000", hi, lo);
        end
        vectors++;

        drive_cycle(1, 6'h1A, 32'h1234_5678, 32'd0, 0);
        if (busy !== 1'b0 || hi !== 32'h1234_5678 || lo !== 32'hFFFF_FFFF) begin
            miscompares++; $display("[TB] FAIL div_zero: got busy=%b %h/%h, expected 0 12345678/ffffffff", busy, hi, lo);
        end
        vectors++;

        // Operands are scrambled during the divide to confirm they were latched.
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i == 3) ? 32'd1 : ($urandom >> $urandom_range(0, 31));
            if (b == 32'd0) b = 32'd3;
            drive_cycle(1, (i % 2 == 0) ? 6'h1A : 6'h1B, a, b, 0);
            repeat (32) drive_cycle($urandom_range(0, 1), 6'h1A, $urandom, $urandom, 0);
            if (busy !== 1'b0 || hi !== model_hi || lo !== model_lo) begin
                miscompares++; $display("[TB] FAIL div_rand: a=%h b=%h got %h/%h, expected %h/%h", a, b, hi, lo, model_hi, model_lo);
            end
            vectors++;
        end
    endtask

    task automatic test_clear_mid_divide;
        drive_cycle(1, 6'h11, 32'h1111_1111, 0, 0);
        drive_cycle(1, 6'h13, 32'h2222_2222, 0, 0);
        drive_cycle(1, 6'h1B, $urandom, 32'd9, 0);
        repeat (10) drive_cycle(1, 6'h11, 32'hA5A5_A5A5, 0, 0);
        drive_cycle(0, 0, 0, 0, 1);
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL clear_busy: got %b, expected 0", busy); end
        vectors++;
        if (hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin
            miscompares++; $display("[TB] FAIL clear_regs: got %h/%h, expected 11111111/22222222", hi, lo);
        end
        vectors++;
        repeat (30) drive_cycle(0, 0, 0, 0, 0);
        if (hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin
            miscompares++; $display("[TB] FAIL clear_late_write: got %h/%h, expected 11111111/22222222", hi, lo);
        end
        vectors++;
    endtask

    task automatic test_back_to_back;
        logic [5:0] f;
        logic [31:0] b;
        logic [5:0] ops [9] = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h2A};
        for (int i = 0; i < 300; i++) begin
            f = ops[$urandom_range(0, 8)];
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            drive_cycle($urandom_range(0, 4) != 0, f, $urandom, b, $urandom_range(0, 19) == 0);
            if (rd_seen !== rd_exp) begin miscompares++; $display("[TB] FAIL b2b_read: step %0d got %h, expected %h", i, rd_seen, rd_exp); end
            vectors++;
            if (hi !== model_hi || lo !== model_lo || busy !== (div_left > 0)) begin
                miscompares++;
                $display("[TB] FAIL b2b_state: step %0d got %h/%h busy=%b, expected %h/%h busy=%b",
                         i, hi, lo, busy, model_hi, model_lo, div_left > 0);
            end
            vectors++;
        end
    endtask

    task automatic test_reset_mid_divide;
        drive_cycle(1, 6'h11, 32'h0BAD_0BAD, 0, 0);
        drive_cycle(1, 6'h1B, 32'hFFFF_0000, 32'd5, 0);
        repeat (12) drive_cycle(1, 6'h1B, 32'hFFFF_0000, 32'd5, 0);
        we = 0;
        #2 reset_n = 0;
        #1;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            miscompares++; $display("[TB] FAIL async_reset: got %h/%h busy=%b, expected 0/0 busy=0", hi, lo, busy);
        end
        vectors++;
        #2 reset_n = 1;
        model_hi = 0; model_lo = 0; div_left = 0;
        @(posedge clk);
        #1;
        repeat (40) drive_cycle(0, 0, 0, 0, 0);
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_no_write: got %h/%h busy=%b, expected 0/0 busy=0", hi, lo, busy);
        end
        vectors++;
        drive_cycle(1, 6'h13, 32'h7777_7777, 0, 0);
        if (lo !== 32'h7777_7777) begin miscompares++; $display("[TB] FAIL post_reset_accept: got %h, expected 77777777", lo); end
        vectors++;
    endtask

    initial begin
        test_reset;
        test_move;
        test_mult;
        test_divide;
        test_clear_mid_divide;
        test_back_to_back;
        test_reset_mid_divide;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/execute_hi_lo_unit.md
EXECUTE_HI_LO_UNIT -- requirements
Module: execute_hi_lo_unit

Interface
REQ-001 Port list SHALL be, clock and reset first:
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 clear  input  1  synchronous flush; aborts any divide in progress.
REQ-005 hi_lo_register_write_execute  input  1  qualifies ALU_function_execute as a HI/LO operation.
REQ-006 ALU_function_execute  input  6  MIPS funct: 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO, 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU.
REQ-007 source_A_execute  input  32  rs operand, already forwarded.
REQ-008 source_B_execute  input  32  rt operand, already forwarded.
REQ-009 hi_lo_read_data_execute  output  32  HI when funct=0x10, LO when funct=0x12, else 0; combinational.
REQ-010 hi_lo_busy_execute  output  1  divide in progress; hazard unit stalls on it.
REQ-011 hi_register / lo_register  output  32 each  current architectural HI/LO.

Function
REQ-012 Operation SHALL be accepted on a rising edge only when hi_lo_register_write_execute=1, clear=0, busy=0.
REQ-013 MTHI/MTLO SHALL write source_A into HI/LO at the accepting edge; the other register is unchanged.
REQ-014 MULT SHALL write the signed 64-bit product at the accepting edge: HI=[63:32], LO=[31:0]; MULTU identical, unsigned.
REQ-015 MFHI/MFLO SHALL not modify state; read data reflects HI/LO before any same-edge write.
REQ-016 DIV/DIVU with source_B!=0 SHALL enter state DIVIDING; 32-iteration restoring divider, one quotient bit per cycle.
REQ-017 FSM states: IDLE, DIVIDING; IDLE->DIVIDING on accepted divide; DIVIDING->IDLE after 32nd iteration edge or on clear.
REQ-018 hi_lo_busy_execute SHALL be registered: high for exactly 32 cycles starting the cycle after acceptance.
REQ-019 HI=remainder, LO=quotient SHALL be written at the edge on which busy falls; no intermediate HI/LO change.
REQ-020 DIV SHALL divide magnitudes; quotient truncates toward zero; remainder takes sign of dividend.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-022 Divide by zero (either variant) SHALL complete at the accepting edge, no busy: HI=source_A, LO=0xFFFFFFFF.
REQ-023 Any HI/LO request while busy=1 SHALL be ignored; MFHI/MFLO while busy return pre-divide values.
REQ-024 clear while DIVIDING SHALL return to IDLE at that edge, busy low next cycle, HI/LO unchanged.
REQ-025 clear while IDLE SHALL block acceptance of that cycle's request.
REQ-026 Unlisted funct codes with hi_lo_register_write_execute=1 SHALL be no-ops.
REQ-027 Divider operands SHALL be latched at acceptance; later source_* changes have no effect.

Reset
REQ-028 reset_n low SHALL immediately force HI=0, LO=0, state IDLE, busy=0, iteration counter=0, internal divider registers=0.
REQ-029 Reset asserted mid-divide SHALL discard the operation; no HI/LO write after release.
REQ-030 First acceptance possible on the first rising edge with reset_n high.

Verification
REQ-031 MULT A=0xFFFFFFFE (-2), B=0x00000003 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-032 DIVU A=100, B=7 -> busy high 32 cycles; on fall HI=2, LO=14; MFLO during busy returns prior LO.
REQ-033 DIV A=-7 (0xFFFFFFF9), B=2 -> after 32 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-034 DIV A=0x12345678, B=0 -> no busy; next cycle HI=0x12345678, LO=0xFFFFFFFF.
REQ-035 DIVU started, clear at iteration 10 -> busy low next cycle, HI/LO keep old values; MTHI 0xA5A5A5A5 during busy ignored.
REQ-036 reset_n pulsed low mid-divide between clock edges -> HI=LO=0, busy=0 immediately, nothing written after release.
